// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle between the fetch unit, the control FSM and instruction memory.
// The slave modport is the fetch unit's view; master is the surrounding system.
interface instr_fetch_unit_if;
    logic        fetch_start;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic [15:0] branch_off;
    logic [25:0] jump_imm;
    logic [31:0] reg_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] Instr;
    logic        IRWrite;
    logic [31:0] PC;
    logic        fetch_busy;
    logic        fetch_err;

    modport master (
        output fetch_start, pc_load, pc_sel, branch_off, jump_imm, reg_target,
        output mem_ack, mem_rdata,
        input  mem_req, mem_addr, Instr, IRWrite, PC, fetch_busy, fetch_err
    );

    modport slave (
        input  fetch_start, pc_load, pc_sel, branch_off, jump_imm, reg_target,
        input  mem_ack, mem_rdata,
        output mem_req, mem_addr, Instr, IRWrite, PC, fetch_busy, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word per request over a
// req/ack handshake and strobes IRWrite for one cycle when the word is delivered.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input logic             clk,
    input logic             reset,
    instr_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, DELIVER, ERROR} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_irWrite;
    logic        r_memReq;
    logic        r_err;
    logic [7:0]  r_cnt;

    logic [31:0] w_redirectPc;
    logic [31:0] w_pcNext;
    logic [31:0] w_instrNext;
    logic        w_irWriteNext;
    logic        w_memReqNext;
    logic        w_errNext;
    logic [7:0]  w_cntNext;

    always_comb begin
        w_redirectPc = r_pc + 32'd4;
        case (bus.pc_sel)
            2'b00: w_redirectPc = r_pc + 32'd4;
            2'b01: w_redirectPc = r_pc + {{14{bus.branch_off[15]}}, bus.branch_off, 2'b00};
            2'b10: w_redirectPc = {r_pc[31:28], bus.jump_imm, 2'b00};
            2'b11: w_redirectPc = {bus.reg_target[31:2], 2'b00};
            default: w_redirectPc = r_pc + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0;
            r_irWrite <= 1'b0;
            r_memReq  <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= 8'h0;
        end else begin
            r_state   <= w_nextState;
            r_pc      <= w_pcNext;
            r_instr   <= w_instrNext;
            r_irWrite <= w_irWriteNext;
            r_memReq  <= w_memReqNext;
            r_err     <= w_errNext;
            r_cnt     <= w_cntNext;
        end
    end

    // An ack on the final allowed wait cycle still completes the fetch.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.fetch_start) w_nextState = REQ;
            REQ: begin
                if (bus.mem_ack)             w_nextState = DELIVER;
                else if (r_cnt == LAST_WAIT) w_nextState = ERROR;
            end
            DELIVER: w_nextState = IDLE;
            ERROR:   w_nextState = ERROR;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_pcNext      = r_pc;
        w_instrNext   = r_instr;
        w_irWriteNext = 1'b0;
        w_memReqNext  = 1'b0;
        w_errNext     = r_err;
        w_cntNext     = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.pc_load) w_pcNext = w_redirectPc;
                if (bus.fetch_start) begin
                    w_memReqNext = 1'b1;
                    w_cntNext    = 8'h0;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    w_instrNext   = bus.mem_rdata;
                    w_pcNext      = r_pc + 32'd4;
                    w_irWriteNext = 1'b1;
                end else if (r_cnt == LAST_WAIT) begin
                    w_errNext = 1'b1;
                end else begin
                    w_memReqNext = 1'b1;
                    w_cntNext    = r_cnt + 8'd1;
                end
            end
            DELIVER: begin
                w_irWriteNext = 1'b0;
            end
            ERROR: begin
                w_errNext = 1'b1;
            end
            default: begin
                w_irWriteNext = 1'b0;
            end
        endcase
    end

    assign bus.mem_req    = r_memReq;
    assign bus.mem_addr   = r_pc;
    assign bus.Instr      = r_instr;
    assign bus.IRWrite    = r_irWrite;
    assign bus.PC         = r_pc;
    assign bus.fetch_busy = (r_state != IDLE);
    assign bus.fetch_err  = r_err;

endmodule
